// File: rtl/pixel_plotter_pkg.sv
// pixel_plotter_pkg: shared state encoding, default screen geometry and framebuffer address width.
package pixel_plotter_pkg;
    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int FB_ADDR_W    = 19;
    typedef enum logic [1:0] {S_IDLE, S_PLOT, S_CLEAR, S_CLEAR_DONE} state_t;
endpackage

// File: rtl/pixel_plotter_fifo.sv
// plot_fifo: first-in first-out request queue; pushes when full and pops when empty are ignored.
module plot_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    logic w_push, w_pop;
    // extra pointer bit distinguishes full from empty
    assign o_empty = r_wr == r_rd;
    assign o_full  = r_wr == {~r_rd[AW], r_rd[AW-1:0]};
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/pixel_plotter.sv
// pixel_plotter: queues pixel requests and writes them to a framebuffer, with clipping and full-screen clear.
module pixel_plotter
    import pixel_plotter_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int COLOR_W    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [10:0]          x,
    input  logic [10:0]          y,
    input  logic [COLOR_W-1:0]   color,
    output logic                 pix_ready,
    input  logic                 clear_start,
    input  logic [COLOR_W-1:0]   clear_color,
    output logic                 clear_done,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    output logic                 busy,
    output logic [15:0]          clip_count
);
    localparam int ENTRY_W = 22 + COLOR_W;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);
    state_t r_state, w_next;
    logic w_full, w_empty, w_pop, w_push, w_in_range, w_st_write;
    logic [ENTRY_W-1:0] w_head;
    logic [10:0] r_st_x, r_st_y;
    logic [COLOR_W-1:0] r_st_color, r_clr_color, r_fb_data;
    logic r_st_valid, r_fb_we;
    logic [FB_ADDR_W-1:0] r_clr_addr, r_fb_addr, w_pix_addr;
    logic [15:0] r_clip;

    plot_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({x, y, color}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign pix_ready  = !w_full;
    assign w_push     = pix_valid && pix_ready;
    assign w_pop      = (r_state == S_IDLE || r_state == S_PLOT) && !w_empty;
    assign w_in_range = (32'(r_st_x) < SCREEN_W) && (32'(r_st_y) < SCREEN_H);
    assign w_st_write = r_st_valid && w_in_range;
    assign w_pix_addr = FB_ADDR_W'(r_st_y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(r_st_x);
    assign clear_done = r_state == S_CLEAR_DONE;
    assign busy       = !w_empty || r_state != S_IDLE;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign clip_count = r_clip;

    // queued pixels drain before a pending clear is honoured
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = !w_empty ? S_PLOT : (clear_start ? S_CLEAR : S_IDLE);
            S_PLOT:       w_next = w_empty ? S_IDLE : S_PLOT;
            S_CLEAR:      w_next = (r_clr_addr == LAST_ADDR) ? S_CLEAR_DONE : S_CLEAR;
            S_CLEAR_DONE: w_next = clear_start ? S_CLEAR_DONE : S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_st_valid  <= 1'b0;
            r_st_x      <= '0;
            r_st_y      <= '0;
            r_st_color  <= '0;
            r_clr_addr  <= '0;
            r_clr_color <= '0;
            r_fb_we     <= 1'b0;
            r_fb_addr   <= '0;
            r_fb_data   <= '0;
            r_clip      <= '0;
        end else begin
            r_state    <= w_next;
            r_st_valid <= w_pop;
            if (w_pop) {r_st_x, r_st_y, r_st_color} <= w_head;
            if (r_state == S_IDLE && w_next == S_CLEAR) begin
                r_clr_addr  <= '0;
                r_clr_color <= clear_color;
            end else if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            // the plot stage is always empty while clearing, so the two write sources never collide
            r_fb_we <= w_st_write || r_state == S_CLEAR;
            if (w_st_write) begin
                r_fb_addr <= w_pix_addr;
                r_fb_data <= r_st_color;
            end else if (r_state == S_CLEAR) begin
                r_fb_addr <= r_clr_addr;
                r_fb_data <= r_clr_color;
            end
            if (r_st_valid && !w_in_range && r_clip != 16'hFFFF) r_clip <= r_clip + 1'b1;
        end
    end
endmodule
